clk_gate_ctrl: RTL and testbench

Central clock-gating controller for up to N gated clock domains. It drives the `en` input of each domain's latch-based clock-gate cell from a per-domain request/acknowledge handshake. A domain is woken on request, acknowledged once its gated clock is stable, and shut off after a programmable idle period. A round-robin scheduler admits at most one domain wake-up per cycle to limit supply inrush.

---
 rtl/cg_pkg.sv | 22 ++
 rtl/cg_domain_fsm.sv | 100 ++++++++++
 rtl/clk_gate_ctrl.sv | 86 ++++++++
 tb/tb_clk_gate_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cg_pkg.sv
// Shared types and sizing helpers for the clock-gating controller.
// Imported by the per-domain FSM and the top-level scheduler.
package cg_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    IDLE = 2'd3
  } cg_state_t;

  localparam int N_DOM_MIN = 1;
  localparam int N_DOM_MAX = 16;

  // Counter must hold the larger of the two reload values without wrapping.
  function automatic int cnt_width(input int wake_cycles, input int idle_cycles);
    int m;
    m = (wake_cycles > idle_cycles) ? wake_cycles : idle_cycles;
    return $clog2(m + 32'sd1);
  endfunction

endpackage

// File: rtl/cg_domain_fsm.sv
// One gated domain: OFF/WAKE/ON/IDLE state register with a shared wake/idle
// counter. Outputs are flops loaded from the next state, so en never glitches.
module cg_domain_fsm
  import cg_pkg::*;
#(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8
) (
  input  logic c,
  input  logic rst,
  input  logic r,
  input  logic grant,
  output logic en,
  output logic ack,
  output logic is_off,
  output logic off_nxt
);

  localparam int CW = cnt_width(WAKE_CYCLES, IDLE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
  localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 32'sd1);
  localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES - 32'sd1);

  cg_state_t       state_r;
  cg_state_t       state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;
  logic            en_r;
  logic            ack_r;
  logic            off_r;

  // Next-state and counter logic; a request in IDLE beats counter expiry.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      OFF: begin
        if (r && grant) begin
          state_nxt_s = WAKE;
          cnt_nxt_s   = WAKE_LOAD;
        end else begin
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      WAKE: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ON;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      ON: begin
        if (!r) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = IDLE_LOAD;
        end else begin
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      IDLE: begin
        if (r) begin
          state_nxt_s = ON;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt_s = OFF;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = OFF;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and decoded output registers.
  always_ff @(posedge c) begin
    if (rst) begin
      state_r <= OFF;
      cnt_r   <= CNT_ZERO;
      en_r    <= 1'b0;
      ack_r   <= 1'b0;
      off_r   <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      en_r    <= (state_nxt_s != OFF);
      ack_r   <= (state_nxt_s == ON) || (state_nxt_s == IDLE);
      off_r   <= (state_nxt_s == OFF);
    end
  end

  assign en      = en_r;
  assign ack     = ack_r;
  assign is_off  = off_r;
  assign off_nxt = (state_nxt_s == OFF);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gating controller: per-domain FSMs plus a round-robin scheduler that
// admits at most one wake-up per cycle to bound supply inrush.
module clk_gate_ctrl
  import cg_pkg::*;
#(
  parameter int N_DOM       = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8
) (
  input  logic             c,
  input  logic             rst,
  input  logic [N_DOM-1:0] req,
  input  logic             force_on,
  output logic [N_DOM-1:0] en,
  output logic [N_DOM-1:0] ack,
  output logic             all_off
);

  localparam int PW = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  if ((N_DOM < N_DOM_MIN) || (N_DOM > N_DOM_MAX) || (WAKE_CYCLES < 1) || (IDLE_CYCLES < 1)) begin : g_param_chk
    $error("clk_gate_ctrl: illegal parameter combination");
  end

  logic [N_DOM-1:0] r_s;
  logic [N_DOM-1:0] cand_s;
  logic [N_DOM-1:0] grant_s;
  logic [N_DOM-1:0] is_off_s;
  logic [N_DOM-1:0] off_nxt_s;
  logic             grant_any_s;
  logic [PW-1:0]    idx_s;
  logic [PW-1:0]    p_r;
  logic [PW-1:0]    p_nxt_s;
  logic             all_off_r;

  assign r_s    = req | {N_DOM{force_on}};
  assign cand_s = is_off_s & r_s;

  // Round-robin search from p; the first OFF domain with a request wins.
  always_comb begin
    grant_s     = {N_DOM{1'b0}};
    grant_any_s = 1'b0;
    idx_s       = {PW{1'b0}};
    p_nxt_s     = p_r;
    for (int k = 0; k < N_DOM; k++) begin
      idx_s = PW'((int'(p_r) + k) % N_DOM);
      if (!grant_any_s && cand_s[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        grant_any_s    = 1'b1;
        p_nxt_s        = PW'((int'(idx_s) + 32'sd1) % N_DOM);
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // Pointer and all_off registers; all_off follows the domains' next states.
  always_ff @(posedge c) begin
    if (rst) begin
      p_r       <= {PW{1'b0}};
      all_off_r <= 1'b1;
    end else begin
      p_r       <= p_nxt_s;
      all_off_r <= &off_nxt_s;
    end
  end

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    cg_domain_fsm #(
      .WAKE_CYCLES (WAKE_CYCLES),
      .IDLE_CYCLES (IDLE_CYCLES)
    ) u_fsm (
      .c       (c),
      .rst     (rst),
      .r       (r_s[i]),
      .grant   (grant_s[i]),
      .en      (en[i]),
      .ack     (ack[i]),
      .is_off  (is_off_s[i]),
      .off_nxt (off_nxt_s[i])
    );
  end

  assign all_off = all_off_r;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_clk_gate_ctrl;

  localparam int N = 4;
  localparam int W = 2;
  localparam int I = 8;

  logic         c = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         force_on;
  logic [N-1:0] en;
  logic [N-1:0] ack;
  logic         all_off;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each domain is awake or not; age counts edges since its grant,
  // quiet counts consecutive no-request edges once its clock is stable.
  bit m_on [N];
  int m_age [N];
  int m_quiet [N];
  int m_p;

  always #5 c = ~c;

  clk_gate_ctrl #(.N_DOM(N), .WAKE_CYCLES(W), .IDLE_CYCLES(I)) dut (
    .c(c), .rst(rst), .req(req), .force_on(force_on),
    .en(en), .ack(ack), .all_off(all_off)
  );

  typedef struct {
    logic         v_rst;
    logic [N-1:0] v_req;
    logic         v_force;
    logic [N-1:0] e_en;
    logic [N-1:0] e_ack;
    logic         e_all_off;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_edge(input logic r_rst, input logic [N-1:0] r_req, input logic r_force);
    bit pre_on [N];
    bit rr;
    bit granted;
    int g;
    if (r_rst) begin
      for (int d = 0; d < N; d++) begin
        m_on[d] = 1'b0; m_age[d] = 0; m_quiet[d] = 0;
      end
      m_p = 0;
      return;
    end
    for (int d = 0; d < N; d++) pre_on[d] = m_on[d];
    for (int d = 0; d < N; d++) begin
      rr = r_req[d] | r_force;
      if (pre_on[d]) begin
        if (m_age[d] >= W) begin
          m_quiet[d] = rr ? 0 : m_quiet[d] + 1;
          if (m_quiet[d] > I) m_on[d] = 1'b0;
        end
        if (m_age[d] < W) m_age[d]++;
      end
    end
    granted = 1'b0;
    for (int k = 0; k < N; k++) begin
      g = (m_p + k) % N;
      if (!granted && !pre_on[g] && (r_req[g] | r_force)) begin
        granted = 1'b1;
        m_on[g] = 1'b1; m_age[g] = 0; m_quiet[g] = 0;
        m_p = (g + 1) % N;
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_en();
    logic [N-1:0] v;
    for (int d = 0; d < N; d++) v[d] = m_on[d];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_ack();
    logic [N-1:0] v;
    for (int d = 0; d < N; d++) v[d] = m_on[d] && (m_age[d] >= W);
    return v;
  endfunction

  task automatic step(input logic r_rst, input logic [N-1:0] r_req, input logic r_force);
    rst = r_rst; req = r_req; force_on = r_force;
    @(posedge c);
    model_edge(r_rst, r_req, r_force);
    #1;
    chk("model_en", 32'(en), 32'(exp_en()));
    chk("model_ack", 32'(ack), 32'(exp_ack()));
    chk("model_all_off", 32'(all_off), 32'(exp_en() == '0));
  endtask

  initial begin
    int waited;
    logic [N-1:0] rq;
    logic [N-1:0] mask;
    rst = 1'b1; req = '0; force_on = 1'b0;
    for (int d = 0; d < N; d++) begin m_on[d] = 0; m_age[d] = 0; m_quiet[d] = 0; end
    m_p = 0;

    // Contention from reset: one grant per edge in order 0..3, ack two edges later.
    tbl[0] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[1] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[2] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0000, 1'b0};
    tbl[3] = '{1'b0, 4'b1111, 1'b0, 4'b0011, 4'b0000, 1'b0};
    tbl[4] = '{1'b0, 4'b1111, 1'b0, 4'b0111, 4'b0001, 1'b0};
    tbl[5] = '{1'b0, 4'b1111, 1'b0, 4'b1111, 4'b0011, 1'b0};
    tbl[6] = '{1'b0, 4'b1111, 1'b0, 4'b1111, 4'b0111, 1'b0};
    tbl[7] = '{1'b0, 4'b1111, 1'b0, 4'b1111, 4'b1111, 1'b0};
    tbl[8] = '{1'b0, 4'b0000, 1'b0, 4'b1111, 4'b1111, 1'b0};
    for (int v = 0; v < 9; v++) begin
      step(tbl[v].v_rst, tbl[v].v_req, tbl[v].v_force);
      chk("tbl_en", 32'(en), 32'(tbl[v].e_en));
      chk("tbl_ack", 32'(ack), 32'(tbl[v].e_ack));
      chk("tbl_all_off", 32'(all_off), 32'(tbl[v].e_all_off));
    end

    // Reset mid-WAKE on domain 1 (pointer moved to 2), then pointer must be back at 0.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    chk("rst_en", 32'(en), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_all_off", 32'(all_off), 32'h1);
    step(1'b0, 4'b1001, 1'b0);
    chk("rst_ptr_grant", 32'(en), 32'h1);

    // Single wake and sleep on domain 2.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    chk("wake_en", 32'(en[2]), 32'h1);
    chk("wake_ack_early", 32'(ack[2]), 32'h0);
    step(1'b0, 4'b0100, 1'b0);
    chk("wake_ack_mid", 32'(ack[2]), 32'h0);
    step(1'b0, 4'b0100, 1'b0);
    chk("wake_ack", 32'(ack[2]), 32'h1);
    step(1'b0, 4'b0100, 1'b0);
    waited = 0;
    do begin
      step(1'b0, 4'b0000, 1'b0);
      waited++;
    end while (en[2] && waited < 50);
    chk("sleep_latency", 32'(waited), 32'(I + 1));
    chk("sleep_ack", 32'(ack[2]), 32'h0);

    // IDLE re-request on domain 1: short drop, then drop to counter zero.
    step(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < W + 2; k++) step(1'b0, 4'b0010, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b0000, 1'b0);
      chk("idle_hold", 32'({en[1], ack[1]}), 32'h3);
    end
    step(1'b0, 4'b0010, 1'b0);
    chk("idle_rereq", 32'({en[1], ack[1]}), 32'h3);
    for (int k = 0; k < I; k++) step(1'b0, 4'b0000, 1'b0);
    chk("idle_cnt_zero", 32'({en[1], ack[1]}), 32'h3);
    step(1'b0, 4'b0010, 1'b0);
    chk("idle_zero_rereq", 32'({en[1], ack[1]}), 32'h3);
    step(1'b0, 4'b0000, 1'b0);
    chk("idle_back_on", 32'({en[1], ack[1]}), 32'h3);

    // Fairness: domain 0 toggling must not starve domain 3.
    step(1'b1, 4'b0000, 1'b0);
    waited = 0;
    while (!en[3] && waited < N + 2) begin
      rq = {1'b1, 2'b00, waited[0] ? 1'b0 : 1'b1};
      step(1'b0, rq, 1'b0);
      waited++;
    end
    chk("fair_grant", 32'(waited <= N), 32'h1);

    // force_on wakes every domain one per edge, then holds them through IDLE_CYCLES.
    step(1'b1, 4'b0000, 1'b0);
    for (int j = 0; j < N; j++) begin
      step(1'b0, 4'b0000, 1'b1);
      chk("force_en", 32'(en), (32'h1 << (j + 1)) - 32'h1);
    end
    for (int k = 0; k < W + 1; k++) step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0100, 1'b1);
    for (int k = 0; k < I; k++) begin
      step(1'b0, 4'b0000, 1'b0);
      chk("force_hold", 32'(en), 32'hF);
    end
    step(1'b0, 4'b0000, 1'b0);
    chk("force_release", 32'(en), 32'h0);
    chk("force_all_off", 32'(all_off), 32'h1);

    // Randomized run: slowly changing requests, occasional force_on and reset.
    rq = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int d = 0; d < N; d++) mask[d] = ($urandom_range(0, 7) == 0);
      rq = rq ^ mask;
      step(($urandom_range(0, 199) == 0), rq, ($urandom_range(0, 29) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
